cache_miss_sequencer: RTL and testbench

Parametrised CPU-side transaction sequencer for the snoopy invalidate-protocol cache; the successor to the fixed-geometry CPU controller FSM.
- Serves CPU read/write requests against the cache arrays.
- Runs block refill, dirty writeback and bus-invalidate with acknowledgement collection over a shared arbitrated bus.
- Block size, cache count, address/data widths and state encoding are all parameters.
- Adds an abort input (snoop conflict) that cancels in-flight writeback/invalidate cleanly.

---
 rtl/cache_miss_sequencer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_cache_miss_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_sequencer.sv
// CPU-side miss/hit sequencer for a snoopy invalidate cache: refill, dirty writeback, invalidate with acks.
// Optional build macro WRITEBACK_FILL_CHAIN_EN chains the last writeback word straight into the refill.
module cache_miss_sequencer #(
  parameter int TAG_WIDTH        = 8,
  parameter int INDEX_WIDTH      = 4,
  parameter int OFFSET_WIDTH     = 2,
  parameter int DATA_WIDTH       = 16,
  parameter int STATE_WIDTH      = 2,
  parameter int NUMBER_OF_CACHES = 4,
  parameter int CACHE_ID         = 0,
  parameter logic [STATE_WIDTH-1:0] INVALID_STATE = '0
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        reqRead,
  input  logic                                        reqWrite,
  input  logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] reqAddress,
  input  logic                                        hit,
  input  logic                                        writeBackRequired,
  input  logic                                        invalidateRequired,
  input  logic [STATE_WIDTH-1:0]                      protocolStateIn,
  input  logic [TAG_WIDTH-1:0]                        victimTag,
  input  logic                                        abort,
  output logic                                        done,
  output logic                                        accessEnable,
  output logic                                        busRequest,
  input  logic                                        busGrant,
  output logic [1:0]                                  busCommand,
  output logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] busAddress,
  output logic                                        busRead,
  output logic                                        busWrite,
  input  logic                                        busFunctionComplete,
  input  logic                                        ackValid,
  input  logic [$clog2(NUMBER_OF_CACHES)-1:0]         ackCacheNumber,
  output logic [OFFSET_WIDTH-1:0]                     cacheOffset,
  output logic                                        cacheWriteData,
  output logic                                        cacheWriteTag,
  output logic                                        cacheWriteState,
  output logic [STATE_WIDTH-1:0]                      cacheStateIn
);

  if (OFFSET_WIDTH < 1 || NUMBER_OF_CACHES < 2 || CACHE_ID >= NUMBER_OF_CACHES || DATA_WIDTH < 1) begin : g_bad_params
    $error("cache_miss_sequencer: illegal parameter combination");
  end

  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_READ = 2'd1;
  localparam logic [1:0] CMD_WB   = 2'd2;
  localparam logic [1:0] CMD_INV  = 2'd3;

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_HIT_WRITE  = 4'd1;
  localparam logic [3:0] S_FINISH     = 4'd2;
  localparam logic [3:0] S_WB_GRANT   = 4'd3;
  localparam logic [3:0] S_WB_WAIT    = 4'd4;
  localparam logic [3:0] S_WB_COMMIT  = 4'd5;
  localparam logic [3:0] S_RD_GRANT   = 4'd6;
  localparam logic [3:0] S_RD_WAIT    = 4'd7;
  localparam logic [3:0] S_RD_WRITE   = 4'd8;
  localparam logic [3:0] S_RD_COMMIT  = 4'd9;
  localparam logic [3:0] S_INV_WAIT   = 4'd10;
  localparam logic [3:0] S_INV_COMMIT = 4'd11;

  localparam logic [NUMBER_OF_CACHES-1:0] ACK_INIT = NUMBER_OF_CACHES'(1) << CACHE_ID;

  logic [3:0]                  r_state;
  logic [1:0]                  r_bus_command;
  logic [OFFSET_WIDTH-1:0]     r_word_counter;
  logic [NUMBER_OF_CACHES-1:0] r_ack_mask;
  logic                        r_done;
  logic                        r_access_enable;
  logic                        r_bus_read;
  logic                        r_bus_write;
  logic                        r_cache_write_data;
  logic                        r_cache_write_tag;
  logic                        r_cache_write_state;
  logic [STATE_WIDTH-1:0]      r_cache_state_in;

  logic [TAG_WIDTH-1:0]        w_req_tag;
  logic [INDEX_WIDTH-1:0]      w_req_index;
  logic [OFFSET_WIDTH-1:0]     w_req_offset;
  logic                        w_request;
  logic                        w_last_word;
  logic                        w_abortable;
  logic [NUMBER_OF_CACHES-1:0] w_ack_mask_next;

  assign w_req_tag    = reqAddress[TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1 -: TAG_WIDTH];
  assign w_req_index  = reqAddress[OFFSET_WIDTH +: INDEX_WIDTH];
  assign w_req_offset = reqAddress[OFFSET_WIDTH-1:0];
  assign w_request    = reqRead | reqWrite;
  assign w_last_word  = &r_word_counter;
  assign w_abortable  = (r_state == S_WB_GRANT) || (r_state == S_WB_WAIT) || (r_state == S_WB_COMMIT) ||
                        (r_state == S_INV_WAIT) || (r_state == S_INV_COMMIT);

  // Ack from any cache (own or duplicate) just sets its bit; out-of-range numbers are dropped.
  always_comb begin
    w_ack_mask_next = r_ack_mask;
    if (busGrant && ackValid && (int'(ackCacheNumber) < NUMBER_OF_CACHES))
      w_ack_mask_next[ackCacheNumber] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state             <= S_IDLE;
      r_bus_command       <= CMD_NONE;
      r_word_counter      <= '0;
      r_ack_mask          <= ACK_INIT;
      r_done              <= 1'b0;
      r_access_enable     <= 1'b0;
      r_bus_read          <= 1'b0;
      r_bus_write         <= 1'b0;
      r_cache_write_data  <= 1'b0;
      r_cache_write_tag   <= 1'b0;
      r_cache_write_state <= 1'b0;
      r_cache_state_in    <= '0;
    end else if (abort && w_abortable) begin
      r_state             <= S_IDLE;
      r_bus_command       <= CMD_NONE;
      r_word_counter      <= '0;
      r_ack_mask          <= ACK_INIT;
      r_bus_read          <= 1'b0;
      r_bus_write         <= 1'b0;
      r_cache_write_data  <= 1'b0;
      r_cache_write_tag   <= 1'b0;
      r_cache_write_state <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bus_command  <= CMD_NONE;
          r_word_counter <= '0;
          if (w_request) begin
            if (hit && reqRead) begin
              r_done          <= 1'b1;
              r_access_enable <= 1'b1;
              r_state         <= S_FINISH;
            end else if (hit && !invalidateRequired) begin
              r_cache_state_in    <= protocolStateIn;
              r_cache_write_state <= 1'b1;
              r_cache_write_data  <= 1'b1;
              r_state             <= S_HIT_WRITE;
            end else if (hit) begin
              r_bus_command <= CMD_INV;
              r_state       <= S_INV_WAIT;
            end else if (writeBackRequired) begin
              r_bus_command <= CMD_WB;
              r_state       <= S_WB_GRANT;
            end else begin
              r_bus_command <= CMD_READ;
              r_state       <= S_RD_GRANT;
            end
          end
        end
        S_HIT_WRITE: begin
          r_cache_write_state <= 1'b0;
          r_cache_write_data  <= 1'b0;
          r_done              <= 1'b1;
          r_access_enable     <= 1'b1;
          r_state             <= S_FINISH;
        end
        S_FINISH: begin
          if (!w_request) begin
            r_done          <= 1'b0;
            r_access_enable <= 1'b0;
            r_state         <= S_IDLE;
          end
        end
        S_WB_GRANT: begin
          if (busGrant) begin
            r_bus_write <= 1'b1;
            r_state     <= S_WB_WAIT;
          end
        end
        S_WB_WAIT: begin
          if (busFunctionComplete) begin
            r_bus_write    <= 1'b0;
            r_word_counter <= r_word_counter + 1'b1;
            if (w_last_word) begin
              r_cache_state_in    <= INVALID_STATE;
              r_cache_write_state <= 1'b1;
              r_state             <= S_WB_COMMIT;
            end else begin
              r_state <= S_WB_GRANT;
            end
          end
        end
        S_WB_COMMIT: begin
          r_cache_write_state <= 1'b0;
`ifdef WRITEBACK_FILL_CHAIN_EN
          r_bus_command <= CMD_READ;
          r_state       <= S_RD_GRANT;
`else
          r_bus_command <= CMD_NONE;
          r_state       <= S_IDLE;
`endif
        end
        S_RD_GRANT: begin
          if (busGrant) begin
            r_bus_read <= 1'b1;
            r_state    <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (busFunctionComplete) begin
            r_cache_write_data <= 1'b1;
            r_state            <= S_RD_WRITE;
          end
        end
        S_RD_WRITE: begin
          r_cache_write_data <= 1'b0;
          r_bus_read         <= 1'b0;
          r_word_counter     <= r_word_counter + 1'b1;
          if (w_last_word) begin
            r_cache_state_in    <= protocolStateIn;
            r_cache_write_tag   <= 1'b1;
            r_cache_write_state <= 1'b1;
            r_state             <= S_RD_COMMIT;
          end else begin
            r_state <= S_RD_GRANT;
          end
        end
        S_RD_COMMIT: begin
          r_cache_write_data  <= 1'b0;
          r_cache_write_tag   <= 1'b0;
          r_cache_write_state <= 1'b0;
          r_bus_command       <= CMD_NONE;
          r_state             <= S_IDLE;
        end
        S_INV_WAIT: begin
          r_ack_mask <= w_ack_mask_next;
          if (&w_ack_mask_next) begin
            r_cache_state_in    <= protocolStateIn;
            r_cache_write_state <= 1'b1;
            r_state             <= S_INV_COMMIT;
          end
        end
        S_INV_COMMIT: begin
          r_cache_write_state <= 1'b0;
          r_ack_mask          <= ACK_INIT;
          r_bus_command       <= CMD_NONE;
          r_state             <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Writeback addresses the victim's block; every other command uses the requester's tag.
  assign busAddress      = {(r_bus_command == CMD_WB) ? victimTag : w_req_tag, w_req_index, r_word_counter};
  assign busRequest      = (r_bus_command != CMD_NONE);
  assign busCommand      = r_bus_command;
  assign busRead         = r_bus_read;
  assign busWrite        = r_bus_write;
  assign done            = r_done;
  assign accessEnable    = r_access_enable;
  assign cacheOffset     = hit ? w_req_offset : r_word_counter;
  assign cacheWriteData  = r_cache_write_data;
  assign cacheWriteTag   = r_cache_write_tag;
  assign cacheWriteState = r_cache_write_state;
  assign cacheStateIn    = r_cache_state_in;

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Scoreboard bench for cache_miss_sequencer: transaction-level reference model predicts bus words,
// cache state writes and done; a negedge monitor compares what the sequencer actually does.
module tb_cache_miss_sequencer;
  localparam int TW = 8, IW = 4, OW = 2, SW = 2, NC = 4, CID = 0, AW = TW + IW + OW;
  localparam logic [1:0] C_NONE = 2'd0, C_READ = 2'd1, C_WB = 2'd2, C_INV = 2'd3;
  localparam logic [1:0] K_WORD = 2'd1, K_STATE = 2'd2, K_DONE = 2'd3;

  typedef struct packed {
    logic [1:0]    kind;
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [SW-1:0] st;
    logic          tagwr;
    logic          datawr;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, reqRead, reqWrite, abort;
  logic [AW-1:0] reqAddress;
  logic          hit, writeBackRequired, invalidateRequired;
  logic [SW-1:0] protocolStateIn;
  logic [TW-1:0] victimTag;
  logic          done, accessEnable, busRequest, busGrant, busRead, busWrite, busFunctionComplete;
  logic [1:0]    busCommand;
  logic [AW-1:0] busAddress;
  logic          ackValid;
  logic [1:0]    ackCacheNumber;
  logic [OW-1:0] cacheOffset;
  logic          cacheWriteData, cacheWriteTag, cacheWriteState;
  logic [SW-1:0] cacheStateIn;

  cache_miss_sequencer #(
    .TAG_WIDTH(TW), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW), .DATA_WIDTH(16), .STATE_WIDTH(SW),
    .NUMBER_OF_CACHES(NC), .CACHE_ID(CID), .INVALID_STATE(2'd0)
  ) dut (
    .clock(clk), .reset(reset), .reqRead(reqRead), .reqWrite(reqWrite), .reqAddress(reqAddress),
    .hit(hit), .writeBackRequired(writeBackRequired), .invalidateRequired(invalidateRequired),
    .protocolStateIn(protocolStateIn), .victimTag(victimTag), .abort(abort), .done(done),
    .accessEnable(accessEnable), .busRequest(busRequest), .busGrant(busGrant), .busCommand(busCommand),
    .busAddress(busAddress), .busRead(busRead), .busWrite(busWrite),
    .busFunctionComplete(busFunctionComplete), .ackValid(ackValid), .ackCacheNumber(ackCacheNumber),
    .cacheOffset(cacheOffset), .cacheWriteData(cacheWriteData), .cacheWriteTag(cacheWriteTag),
    .cacheWriteState(cacheWriteState), .cacheStateIn(cacheStateIn)
  );

  int checks = 0;
  int errors = 0;
  ev_t exp_q[$];
  bit mon_en = 1'b0;
  bit env_clear = 1'b1;

  // Datapath stand-in: tag/state arrays updated by the sequencer's strobes, lookup answered from them.
  // State 0 invalid, 1 shared (clean), 3 modified (dirty).
  logic [TW-1:0] env_tag [16];
  logic [SW-1:0] env_state [16];
  logic [TW-1:0] req_tag;
  logic [IW-1:0] req_idx;
  assign req_tag            = reqAddress[AW-1 -: TW];
  assign req_idx            = reqAddress[OW +: IW];
  assign victimTag          = env_tag[req_idx];
  assign hit                = (env_state[req_idx] != 2'd0) && (env_tag[req_idx] == req_tag);
  assign writeBackRequired  = !hit && (env_state[req_idx] == 2'd3);
  assign invalidateRequired = hit && reqWrite && (env_state[req_idx] == 2'd1);
  assign protocolStateIn    = reqWrite ? 2'd3 : 2'd1;

  always @(posedge clk) begin
    if (env_clear) begin
      for (int i = 0; i < 16; i++) begin
        env_tag[i]   <= '0;
        env_state[i] <= '0;
      end
    end else begin
      if (cacheWriteTag)   env_tag[req_idx]   <= req_tag;
      if (cacheWriteState) env_state[req_idx] <= cacheStateIn;
    end
  end

  function automatic ev_t mk(input logic [1:0] kind, input logic [1:0] cmd, input logic [AW-1:0] addr,
                             input logic [SW-1:0] st, input logic tw, input logic dw);
    ev_t e;
    e.kind = kind; e.cmd = cmd; e.addr = addr; e.st = st; e.tagwr = tw; e.datawr = dw;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic got(input ev_t e);
    ev_t x;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event_unexpected: got %h, required none", e);
    end else begin
      x = exp_q.pop_front();
      if (x !== e) begin
        errors++;
        $display("FAIL event: got %h, required %h", e, x);
      end
    end
  endtask

  // Monitor first (values the DUT saw at the last edge), then bus/ack responder drives the next cycle.
  logic [NC-1:0] ack_seen = 4'b0001;
  bit p_bw = 0, p_br = 0, p_cws = 0, p_done = 0, chain_pending = 0;
  int fill_cnt = 0;
  always @(negedge clk) begin
    if (ackValid) ack_seen[ackCacheNumber] = 1'b1;
    if (busCommand != C_INV) ack_seen = NC'(1) << CID;
    if (busCommand != C_READ) fill_cnt = 0;
    if (chain_pending) begin
`ifdef WRITEBACK_FILL_CHAIN_EN
      chk("chain_cmd_after_wb", int'(busCommand), int'(C_READ));
`else
      chk("chain_cmd_after_wb", int'(busCommand), int'(C_NONE));
`endif
      chain_pending = 0;
    end
    if (mon_en) begin
      if (busWrite && !p_bw) got(mk(K_WORD, busCommand, busAddress, '0, 1'b0, 1'b0));
      if (busRead && !p_br)  got(mk(K_WORD, busCommand, busAddress, '0, 1'b0, 1'b0));
      if (cacheWriteData && busRead) begin
        chk("fill_offset", int'(cacheOffset), fill_cnt % 4);
        fill_cnt++;
      end
      if (cacheWriteState && !p_cws) begin
        if (busCommand == C_INV) chk("inv_all_acks", int'(ack_seen), 15);
        if (busCommand == C_WB) chain_pending = 1;
        got(mk(K_STATE, 2'd0, '0, cacheStateIn, cacheWriteTag, cacheWriteData));
      end
      if (done && !p_done) begin
        chk("access_enable", int'(accessEnable), 1);
        got(mk(K_DONE, 2'd0, '0, '0, 1'b0, 1'b0));
      end
    end
    p_bw = busWrite; p_br = busRead; p_cws = cacheWriteState; p_done = done;
    busGrant            = busRequest && ($urandom_range(0, 3) != 0);
    busFunctionComplete = (busRead || busWrite) && !busFunctionComplete && ($urandom_range(0, 2) != 0);
    ackValid            = busGrant && (busCommand == C_INV) && ($urandom_range(0, 1) == 1);
    ackCacheNumber      = 2'($urandom_range(0, NC - 1));
  end

  // Reference model: one cache line per index, predicted from the protocol rules alone.
  logic [TW-1:0] ref_tag [16];
  logic [SW-1:0] ref_state [16];
  int n_req = 0;

  task automatic do_req(input bit wr, input logic [TW-1:0] tag, input logic [IW-1:0] idx, input logic [OW-1:0] off);
    bit hitr, plain_rd, plain_wr;
    int lat;
    hitr     = (ref_state[idx] != 0) && (ref_tag[idx] == tag);
    plain_rd = hitr && !wr;
    plain_wr = hitr && wr && (ref_state[idx] != 2'd1);
    if (!hitr) begin
      if (ref_state[idx] == 2'd3) begin
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(K_WORD, C_WB, {ref_tag[idx], idx, 2'(k)}, '0, 1'b0, 1'b0));
        exp_q.push_back(mk(K_STATE, 2'd0, '0, 2'd0, 1'b0, 1'b0));
      end
      for (int k = 0; k < 4; k++) exp_q.push_back(mk(K_WORD, C_READ, {tag, idx, 2'(k)}, '0, 1'b0, 1'b0));
      exp_q.push_back(mk(K_STATE, 2'd0, '0, wr ? 2'd3 : 2'd1, 1'b1, 1'b0));
      ref_tag[idx]   = tag;
      ref_state[idx] = wr ? 2'd3 : 2'd1;
    end
    if (wr) begin
      if (ref_state[idx] == 2'd1) exp_q.push_back(mk(K_STATE, 2'd0, '0, 2'd3, 1'b0, 1'b0));
      exp_q.push_back(mk(K_STATE, 2'd0, '0, 2'd3, 1'b0, 1'b1));
      ref_state[idx] = 2'd3;
    end
    exp_q.push_back(mk(K_DONE, 2'd0, '0, '0, 1'b0, 1'b0));
    reqAddress = {tag, idx, off};
    reqRead    = !wr;
    reqWrite   = wr;
    lat = 0;
    while (!done && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done", lat);
    end else if (plain_rd) chk("hit_read_latency", lat, 1);
    else if (plain_wr) chk("hit_write_latency", lat, 2);
    $display("req %0d %s addr=%h cycles=%0d", n_req, wr ? "WR" : "RD", reqAddress, lat);
    n_req++;
    reqRead = 0; reqWrite = 0;
    lat = 0;
    while (done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("done_cleared", int'(done), 0);
  endtask

  task automatic chk_quiet_outputs(input string tag);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_access_enable"}, int'(accessEnable), 0);
    chk({tag, "_bus_request"}, int'(busRequest), 0);
    chk({tag, "_bus_command"}, int'(busCommand), 0);
    chk({tag, "_bus_read"}, int'(busRead), 0);
    chk({tag, "_bus_write"}, int'(busWrite), 0);
    chk({tag, "_word_counter"}, int'(busAddress[OW-1:0]), 0);
    chk({tag, "_wr_data"}, int'(cacheWriteData), 0);
    chk({tag, "_wr_tag"}, int'(cacheWriteTag), 0);
    chk({tag, "_wr_state"}, int'(cacheWriteState), 0);
  endtask

  initial begin
    logic [TW-1:0] tags [4];
    int cnt;
    tags[0] = 8'hA5; tags[1] = 8'h3C; tags[2] = 8'h11; tags[3] = 8'h7E;
    for (int i = 0; i < 16; i++) begin
      ref_tag[i] = '0;
      ref_state[i] = '0;
    end
    reset = 1; reqRead = 0; reqWrite = 0; abort = 0; reqAddress = '0;
    busGrant = 0; busFunctionComplete = 0; ackValid = 0; ackCacheNumber = 0;
    repeat (3) @(negedge clk);
    chk_quiet_outputs("reset");
    chk("reset_state_in", int'(cacheStateIn), 0);
    env_clear = 0; reset = 0; mon_en = 1;
    @(negedge clk);

    // Directed: dirty line A5 at index 2, then a read of 3C forces writeback + refill, then hits.
    do_req(1'b1, 8'hA5, 4'd2, 2'd1);
    do_req(1'b0, 8'h3C, 4'd2, 2'd3);
    do_req(1'b0, 8'h3C, 4'd2, 2'd2);
    do_req(1'b1, 8'h3C, 4'd2, 2'd0);
    do_req(1'b1, 8'h3C, 4'd2, 2'd1);
    // abort held through a clean read miss must be ignored
    abort = 1;
    do_req(1'b0, 8'h7E, 4'd7, 2'd0);
    abort = 0;

    for (int i = 0; i < 40; i++)
      do_req(1'($urandom_range(0, 1)), tags[$urandom_range(0, 3)], 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

    // Abort during the second writeback word of a dirty miss.
    do_req(1'b1, 8'h11, 4'd5, 2'd0);
    mon_en = 0;
    reqAddress = {8'h22, 4'd5, 2'd0}; reqRead = 1;
    cnt = 0;
    while (!(busWrite && busAddress[OW-1:0] == 2'd1) && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    chk("abort_reached_word2", int'(busWrite && busAddress[OW-1:0] == 2'd1), 1);
    abort = 1; reqRead = 0;
    @(negedge clk);
    abort = 0;
    chk_quiet_outputs("abort");
    @(negedge clk);
    chk("abort_stays_idle", int'(busCommand), 0);
    mon_en = 1;

    // Reset while waiting for a refill word.
    mon_en = 0;
    reqAddress = {8'h33, 4'd9, 2'd0}; reqRead = 1;
    cnt = 0;
    while (!(busRead && !cacheWriteData) && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    chk("reset_reached_rd_wait", int'(busRead && !cacheWriteData), 1);
    reset = 1; reqRead = 0;
    @(negedge clk);
    reset = 0;
    chk_quiet_outputs("midreset");
    @(negedge clk);
    chk("midreset_stays_idle", int'(busRequest), 0);
    mon_en = 1;

    for (int i = 0; i < 8; i++)
      do_req(1'($urandom_range(0, 1)), tags[$urandom_range(0, 3)], 4'($urandom_range(4, 9)), 2'($urandom_range(0, 3)));
    do_req(1'b0, 8'h33, 4'd9, 2'd2);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
